// File: rtl/sc_reglfsr_pkg.sv
// Shared types and constants for the SC_Reg LFSR generator.
// Holds the FSM encoding, mode codes and default tap masks.
package sc_reglfsr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_BURST = 2'd2,
    ST_DONE  = 2'd3
  } lfsr_fsm_e;

  localparam logic MODE_FIB = 1'b0;
  localparam logic MODE_GAL = 1'b1;

  localparam logic [3:0]  TAPS_W4  = 4'h9;
  localparam logic [7:0]  TAPS_W8  = 8'hB8;
  localparam logic [15:0] TAPS_W16 = 16'hB400;
  localparam logic [31:0] TAPS_W32 = 32'h8020_0003;

  // Zero means no stock mask exists for that width.
  function automatic logic [31:0] default_taps(
    input int unsigned w
  );
    logic [31:0] t;
    t = 32'h0;
    case (w)
      4:       t = {28'h0, TAPS_W4};
      8:       t = {24'h0, TAPS_W8};
      16:      t = {16'h0, TAPS_W16};
      32:      t = TAPS_W32;
      default: t = 32'h0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/sc_reglfsr_gen_step.sv
// Combinational LFSR next-state function.
// Fibonacci shifts left; Galois shifts right with masked feedback.
module sc_lfsr_step
  import sc_reglfsr_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_state,
  input  logic             i_mode,
  input  logic [WIDTH-1:0] i_taps,
  output logic [WIDTH-1:0] o_next
);

  logic             w_fb;
  logic [WIDTH-1:0] w_fib;
  logic [WIDTH-1:0] w_gal;

  assign w_fb  = ^(i_state & i_taps);
  assign w_fib = {i_state[WIDTH-2:0], w_fb};
  assign w_gal = (i_state >> 1)
               ^ (i_state[0] ? i_taps : '0);

  assign o_next = (i_mode == MODE_FIB) ? w_fib
                                       : w_gal;

endmodule

// File: rtl/sc_reglfsr_gen.sv
// LFSR pseudo-random generator with seed load,
// free-run stepping and counted bursts.
module sc_reglfsr_gen
  import sc_reglfsr_pkg::*;
#(
  parameter int unsigned LFSR_WIDTH = 8,
  parameter logic [LFSR_WIDTH-1:0] LFSR_TAPS =
    LFSR_WIDTH'(default_taps(LFSR_WIDTH)),
  parameter logic [LFSR_WIDTH-1:0] LFSR_SEED_DEFAULT =
    LFSR_WIDTH'(1),
  parameter int unsigned BURST_CNT_WIDTH = 8
) (
  input  logic                       SC_RegSHIFTER_CLOCK_50,
  input  logic                       SC_RegSHIFTER_RESET_InHigh,
  input  logic                       load_In,
  input  logic [LFSR_WIDTH-1:0]      seed_InBUS,
  input  logic                       mode_In,
  input  logic                       enable_In,
  input  logic                       burst_start_In,
  input  logic [BURST_CNT_WIDTH-1:0] burst_len_InBUS,
  output logic [LFSR_WIDTH-1:0]      data_OutBUS,
  output logic                       valid_Out,
  output logic                       busy_Out,
  output logic                       done_Out,
  output logic                       wrap_Out,
  output logic                       zero_seed_err_Out
);

  if (LFSR_WIDTH < 4 || LFSR_WIDTH > 32) begin : g_bad_width
    $error("sc_reglfsr_gen: LFSR_WIDTH out of 4..32");
  end
  if (LFSR_SEED_DEFAULT == '0) begin : g_bad_seed
    $error("sc_reglfsr_gen: LFSR_SEED_DEFAULT is zero");
  end
  if (BURST_CNT_WIDTH < 1 || BURST_CNT_WIDTH > 32) begin : g_bad_cnt
    $error("sc_reglfsr_gen: BURST_CNT_WIDTH out of 1..32");
  end

  localparam logic [BURST_CNT_WIDTH-1:0] CNT_ONE =
    BURST_CNT_WIDTH'(1);

  logic [LFSR_WIDTH-1:0]      r_state;
  logic [LFSR_WIDTH-1:0]      r_seed;
  lfsr_fsm_e                  r_fsm;
  logic [BURST_CNT_WIDTH-1:0] r_cnt;
  logic                       r_valid;
  logic                       r_busy;
  logic                       r_done;
  logic                       r_wrap;
  logic                       r_err;

  logic [LFSR_WIDTH-1:0]      w_next;
  logic [LFSR_WIDTH-1:0]      w_seed_eff;
  logic                       w_seed_zero;
  lfsr_fsm_e                  w_fsm_nxt;
  logic [BURST_CNT_WIDTH-1:0] w_cnt_nxt;
  logic                       w_step;

  sc_lfsr_step #(
    .WIDTH(LFSR_WIDTH)
  ) u_step (
    .i_state(r_state),
    .i_mode (mode_In),
    .i_taps (LFSR_TAPS),
    .o_next (w_next)
  );

  assign w_seed_zero = (seed_InBUS == '0);
  assign w_seed_eff  = w_seed_zero ? LFSR_SEED_DEFAULT
                                   : seed_InBUS;

  // DONE shares IDLE's decisions; it only differs in done_Out.
  always_comb begin
    w_step    = 1'b0;
    w_fsm_nxt = r_fsm;
    w_cnt_nxt = r_cnt;
    if (load_In) begin
      w_fsm_nxt = ST_IDLE;
      w_cnt_nxt = '0;
    end else begin
      unique case (r_fsm)
        ST_BURST: begin
          w_step    = 1'b1;
          w_cnt_nxt = r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) begin
            w_fsm_nxt = ST_DONE;
          end
        end
        ST_IDLE, ST_RUN, ST_DONE: begin
          if (burst_start_In) begin
            if (burst_len_InBUS != '0) begin
              w_fsm_nxt = ST_BURST;
              w_cnt_nxt = burst_len_InBUS;
            end else begin
              w_fsm_nxt = ST_DONE;
              w_cnt_nxt = '0;
            end
          end else if (enable_In) begin
            w_step    = 1'b1;
            w_fsm_nxt = ST_RUN;
          end else begin
            w_fsm_nxt = ST_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge SC_RegSHIFTER_CLOCK_50 or
              posedge SC_RegSHIFTER_RESET_InHigh) begin
    if (SC_RegSHIFTER_RESET_InHigh) begin
      r_state <= LFSR_SEED_DEFAULT;
      r_seed  <= LFSR_SEED_DEFAULT;
      r_fsm   <= ST_IDLE;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_wrap  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_fsm   <= w_fsm_nxt;
      r_cnt   <= w_cnt_nxt;
      r_valid <= w_step;
      r_busy  <= (w_fsm_nxt == ST_BURST);
      r_done  <= (w_fsm_nxt == ST_DONE);
      r_wrap  <= w_step && (w_next == r_seed);
      if (load_In) begin
        r_state <= w_seed_eff;
        r_seed  <= w_seed_eff;
        r_err   <= w_seed_zero;
      end else if (w_step) begin
        r_state <= w_next;
      end
    end
  end

  assign data_OutBUS       = r_state;
  assign valid_Out         = r_valid;
  assign busy_Out          = r_busy;
  assign done_Out          = r_done;
  assign wrap_Out          = r_wrap;
  assign zero_seed_err_Out = r_err;

endmodule

// File: tb/tb_sc_reglfsr_gen.sv
// Directed and random checks of sc_reglfsr_gen
// against a behavioural step/burst model.
module tb_sc_reglfsr_gen;

  localparam logic [7:0] TAPS = 8'hB8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ld = 1'b0;
  logic [7:0] seed = 8'h00;
  logic       mode = 1'b0;
  logic       en = 1'b0;
  logic       bs = 1'b0;
  logic [7:0] len = 8'h00;

  logic [7:0] data;
  logic       valid, busy, done, wrap, err;

  int n_vec = 0;
  int n_err = 0;

  int m_s, m_ref, m_left;
  bit m_err, m_valid, m_done, m_wrap;

  logic [7:0] fib_exp [5] = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23};
  logic [7:0] gal_exp [5] = '{8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};
  logic [7:0] bur_exp [3] = '{8'h02, 8'h04, 8'h08};

  bit         r_l, r_g, r_e, r_b;
  logic [7:0] r_sd, r_ln;

  sc_reglfsr_gen dut (
    .SC_RegSHIFTER_CLOCK_50    (clk),
    .SC_RegSHIFTER_RESET_InHigh(rst),
    .load_In                   (ld),
    .seed_InBUS                (seed),
    .mode_In                   (mode),
    .enable_In                 (en),
    .burst_start_In            (bs),
    .burst_len_InBUS           (len),
    .data_OutBUS               (data),
    .valid_Out                 (valid),
    .busy_Out                  (busy),
    .done_Out                  (done),
    .wrap_Out                  (wrap),
    .zero_seed_err_Out         (err)
  );

  always #10 clk = ~clk;

  function automatic int lfsr_next(int s, bit gal);
    if (!gal)
      return ((s * 2) + ($countones(s & TAPS) % 2)) % 256;
    return (s / 2) ^ ((s % 2 == 1) ? int'(TAPS) : 0);
  endfunction

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_s = 1; m_ref = 1; m_left = 0;
    m_err = 0; m_valid = 0; m_done = 0; m_wrap = 0;
  endtask

  task automatic m_step(bit l, logic [7:0] sd, bit g,
                        bit e, bit b, logic [7:0] ln);
    m_valid = 0; m_done = 0; m_wrap = 0;
    if (l) begin
      m_s    = (sd == 0) ? 1 : int'(sd);
      m_ref  = m_s;
      m_err  = (sd == 0);
      m_left = 0;
    end else if (m_left > 0) begin
      m_s     = lfsr_next(m_s, g);
      m_valid = 1;
      m_wrap  = (m_s == m_ref);
      m_left--;
      m_done  = (m_left == 0);
    end else if (b) begin
      if (ln != 0) m_left = int'(ln);
      else m_done = 1;
    end else if (e) begin
      m_s     = lfsr_next(m_s, g);
      m_valid = 1;
      m_wrap  = (m_s == m_ref);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".data"}, data, m_s);
    chk({tag, ".valid"}, valid, m_valid);
    chk({tag, ".busy"}, busy, (m_left > 0));
    chk({tag, ".done"}, done, m_done);
    chk({tag, ".wrap"}, wrap, m_wrap);
    chk({tag, ".err"}, err, m_err);
  endtask

  task automatic cyc(bit l, logic [7:0] sd, bit g, bit e,
                     bit b, logic [7:0] ln, string tag);
    ld = l; seed = sd; mode = g; en = e; bs = b; len = ln;
    @(posedge clk);
    #1;
    m_step(l, sd, g, e, b, ln);
    check_all(tag);
  endtask

  initial begin
    m_reset();
    #1 rst = 1'b1;
    #24;
    check_all("reset");
    chk("reset.data1", data, 8'h01);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      cyc(0, 8'h00, 0, 1, 0, 8'd0, "fib");
      chk("fib.seq", data, fib_exp[i]);
    end

    cyc(1, 8'h01, 1, 1, 0, 8'd0, "gal.load");
    chk("gal.load.data", data, 8'h01);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 8'h00, 1, 1, 0, 8'd0, "gal");
      chk("gal.seq", data, gal_exp[i]);
    end

    cyc(1, 8'h01, 0, 0, 0, 8'd0, "bur.load");
    cyc(0, 8'h00, 0, 0, 1, 8'd3, "bur.start");
    chk("bur.start.busy", busy, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 8'h00, 0, 0, 0, 8'd0, "bur");
      chk("bur.seq", data, bur_exp[i]);
      chk("bur.busy", busy, (i < 2));
      chk("bur.done", done, (i == 2));
    end
    cyc(0, 8'h00, 0, 0, 0, 8'd0, "bur.hold");
    chk("bur.hold.data", data, 8'h08);

    cyc(0, 8'h00, 0, 0, 1, 8'd0, "bur.zero");
    chk("bur.zero.done", done, 1'b1);

    cyc(1, 8'h00, 0, 0, 0, 8'd0, "zs.load");
    chk("zs.data", data, 8'h01);
    chk("zs.err", err, 1'b1);
    for (int i = 0; i < 3; i++)
      cyc(0, 8'h00, 0, 1, 0, 8'd0, "zs.run");
    chk("zs.sticky", err, 1'b1);
    cyc(1, 8'h5A, 0, 0, 0, 8'd0, "zs.clear");
    chk("zs.clear.err", err, 1'b0);
    chk("zs.clear.data", data, 8'h5A);

    cyc(1, 8'h33, 0, 0, 0, 8'd0, "ab.load");
    cyc(0, 8'h00, 0, 0, 1, 8'd8, "ab.start");
    for (int i = 0; i < 3; i++)
      cyc(0, 8'h00, 1, 0, 1, 8'd2, "ab.run");
    cyc(1, 8'h77, 0, 1, 0, 8'd0, "ab.abort");
    chk("ab.data", data, 8'h77);
    chk("ab.busy", busy, 1'b0);
    chk("ab.done", done, 1'b0);
    cyc(0, 8'h00, 0, 0, 0, 8'd0, "ab.after");
    chk("ab.after.done", done, 1'b0);

    cyc(1, 8'h01, 0, 1, 0, 8'd0, "wr.load");
    for (int i = 1; i <= 520; i++) begin
      cyc(0, 8'h00, 0, 1, 0, 8'd0, "wr");
      chk("wr.period", wrap, (i % 255 == 0));
    end

    @(posedge clk);
    #4 rst = 1'b1;
    #1;
    m_reset();
    check_all("rst.mid");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 400; i++) begin
      r_l  = ($urandom % 16 == 0);
      r_sd = ($urandom % 8 == 0) ? 8'h00 : 8'($urandom);
      r_g  = 1'($urandom);
      r_e  = ($urandom % 4 != 0);
      r_b  = ($urandom % 6 == 0);
      r_ln = 8'($urandom_range(0, 6));
      cyc(r_l, r_sd, r_g, r_e, r_b, r_ln, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sc_reglfsr_gen.md
Name: sc_reglfsr_gen

Overview:
- Parametrised pseudo-random generator: a linear-feedback shift register with runtime seed load and selectable Fibonacci or Galois feedback.
- Supports free-running stepping and counted bursts, with valid, done and wrap flags.
- Feeds game and test-pattern logic that previously consumed the fixed 8-bit shifter output; sits next to the other SC_Reg* blocks in the datapath.

Parameters:
- LFSR_WIDTH, 8: state and output width; legal range 4..32.
- LFSR_TAPS, 8'hB8: feedback tap mask, LFSR_WIDTH bits wide; default is x^8+x^6+x^5+x^4+1.
- LFSR_SEED_DEFAULT, 1: reset state and substitute for an all-zero seed; must be nonzero.
- BURST_CNT_WIDTH, 8: width of the burst length input.

Ports:
- SC_RegSHIFTER_CLOCK_50  in  1  system clock; all logic on its rising edge.
- SC_RegSHIFTER_RESET_InHigh  in  1  reset, asynchronous, active-high.
- load_In  in  1  one-cycle pulse; load seed_InBUS into the state.
- seed_InBUS  in  LFSR_WIDTH  seed value.
- mode_In  in  1  0 = Fibonacci, 1 = Galois; sampled every step.
- enable_In  in  1  free-run step request; level-sensitive.
- burst_start_In  in  1  one-cycle pulse; start a burst of burst_len_InBUS steps.
- burst_len_InBUS  in  BURST_CNT_WIDTH  burst step count; sampled with burst_start_In.
- data_OutBUS  out  LFSR_WIDTH  current LFSR state, registered.
- valid_Out  out  1  high for the cycle after each step.
- busy_Out  out  1  high while the FSM is in BURST.
- done_Out  out  1  one-cycle pulse at burst completion.
- wrap_Out  out  1  one-cycle pulse when the state returns to the last loaded seed.
- zero_seed_err_Out  out  1  sticky; an all-zero seed was loaded.

Behaviour:
- Reset (asynchronous, any time, including mid-burst):
  - state = LFSR_SEED_DEFAULT; seed copy = LFSR_SEED_DEFAULT.
  - FSM = IDLE; burst counter = 0.
  - valid_Out, busy_Out, done_Out, wrap_Out and zero_seed_err_Out all 0.
- Step rules (W = LFSR_WIDTH, S = state):
  - Fibonacci: fb = XOR-reduce(S & LFSR_TAPS); next = {S[W-2:0], fb}.
  - Galois: next = (S >> 1) ^ (S[0] ? LFSR_TAPS : 0).
- Latency: data_OutBUS shows the new state 1 cycle after the triggering edge; valid_Out is asserted in that same cycle.
- FSM states are IDLE, RUN, BURST and DONE.
  - IDLE: burst_start_In with len != 0 -> BURST (counter = len); burst_start_In with len == 0 -> DONE (no step); enable_In -> RUN.
  - RUN: steps every cycle while enable_In = 1; enable_In = 0 -> IDLE; burst_start_In -> BURST (enable_In is ignored during the burst).
  - BURST: steps every cycle and decrements the counter; on the step that brings the counter to 0 -> DONE.
  - DONE: done_Out = 1 for exactly one cycle, then IDLE, or RUN if enable_In = 1.
- Priority within a cycle: reset > load_In > burst_start_In > enable_In.
- load_In:
  - Takes effect next cycle from any state; no step occurs in that cycle.
  - Aborts any active burst -> IDLE, with no done_Out.
  - The loaded value is also captured as the wrap-reference seed copy.
- Zero seed: if seed_InBUS is 0, state and seed copy become LFSR_SEED_DEFAULT and zero_seed_err_Out is set. It stays set until a nonzero load or reset.
- burst_start_In while in BURST is ignored; the running burst is unaffected.
- wrap_Out pulses with valid_Out whenever a step produces a state equal to the seed copy (full period for maximal taps). The counter never wraps; width is checked at elaboration.
- The state never becomes 0 through stepping with nonzero taps.

Decomposition:
- Package sc_reglfsr_pkg holds:
  - FSM state enum (IDLE/RUN/BURST/DONE, 2-bit).
  - MODE_FIB = 0 and MODE_GAL = 1 constants.
  - Default tap masks for widths 4/8/16/32: 4'h9, 8'hB8, 16'hB400, 32'h80200003.
- One sub-module, sc_lfsr_step: purely combinational next-state function over (state, mode, taps). Instantiated once; reusable by other generators.

Test Plan:
- Reset released, no load; enable_In = 1, mode 0 -> data_OutBUS 01,02,04,08,11,23 on successive cycles, valid_Out high each cycle.
- load_In with seed 0x01, mode 1, enable_In = 1 -> data_OutBUS B8,5C,2E,17,B3.
- burst_start_In with len = 3, mode 0 from seed 0x01 -> busy_Out high 3 cycles; data 02,04,08; done_Out pulses once the cycle after the final step; state then holds at 08.
- load_In with seed 0x00 -> data_OutBUS = 0x01; zero_seed_err_Out = 1; stays 1 until a load of 0x5A clears it.
- load_In of 0x77 during a burst with 5 steps remaining -> FSM goes IDLE; no done_Out; data_OutBUS = 0x77; busy_Out = 0 next cycle.
- Seed 0x01, mode 0, enable_In held -> wrap_Out pulses exactly at step 255 and every 255 steps after; reset asserted mid-run -> all outputs 0 and data_OutBUS = 0x01 immediately.
